// File: rtl/opamp_out_monitor_pkg.sv
// Shared definitions for the op-amp output monitor: state encoding and default limits.
package opamp_pkg;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_LINEAR  = 2'd1,
      ST_SAT_POS = 2'd2,
      ST_SAT_NEG = 2'd3
   } state_e;

   localparam int SAMPLE_W    = 16;
   localparam int SAT_HI_DEF  = 12000;
   localparam int SAT_LO_DEF  = -12000;
   localparam int HYST_DEF    = 500;

endpackage

// File: rtl/opamp_out_monitor_if.sv
// Sample input and status outputs of the op-amp output monitor.
interface opamp_out_monitor_if #(
   parameter int WIDTH = opamp_pkg::SAMPLE_W
);
   logic                    en;
   logic signed [WIDTH-1:0] vin;
   logic signed [WIDTH-1:0] avg_out;
   logic                    avg_valid;
   logic [1:0]              state;
   logic                    sat_pos;
   logic                    sat_neg;
   logic                    zero_cross;

   modport master (output en, vin,
                   input  avg_out, avg_valid, state, sat_pos, sat_neg, zero_cross);
   modport slave  (input  en, vin,
                   output avg_out, avg_valid, state, sat_pos, sat_neg, zero_cross);
endinterface

// File: rtl/opamp_out_monitor_mavg.sv
// Sample divider plus 2^AVG_LOG2-deep moving average with floor rounding.
module opamp_mavg
   import opamp_pkg::*;
#(
   parameter int WIDTH      = SAMPLE_W,
   parameter int AVG_LOG2   = 3,
   parameter int SAMPLE_DIV = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_i,
   input  logic signed [WIDTH-1:0] vin_i,
   output logic signed [WIDTH-1:0] avg_o,
   output logic                    avg_valid_o
);
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SW    = WIDTH + AVG_LOG2;
   localparam int CW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CW-1:0]           div_q;
   logic                    strobe;
   logic                    strobe_q;
   logic signed [WIDTH-1:0] win_q [DEPTH];
   logic signed [SW-1:0]    sum_q;
   logic signed [SW-1:0]    sum_d;
   logic [AVG_LOG2:0]       fill_q;
   logic                    full;

   assign strobe = en_i && (div_q == CW'(SAMPLE_DIV - 1));
   assign sum_d  = sum_q + SW'(vin_i) - SW'(win_q[DEPTH-1]);
   assign full   = (fill_q == (AVG_LOG2 + 1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q       <= '0;
         strobe_q    <= 1'b0;
         sum_q       <= '0;
         fill_q      <= '0;
         avg_o       <= '0;
         avg_valid_o <= 1'b0;
         for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      end else begin
         if (en_i) div_q <= strobe ? '0 : div_q + 1'b1;
         strobe_q <= strobe;
         if (strobe) begin
            win_q[0] <= vin_i;
            for (int i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
            sum_q <= sum_d;
            if (!full) fill_q <= fill_q + 1'b1;
         end
         // Average of the sample captured one edge earlier; fill_q already counts it.
         avg_valid_o <= strobe_q && full;
         if (strobe_q && full) avg_o <= WIDTH'(sum_q >>> AVG_LOG2);
      end
   end
endmodule

// File: rtl/opamp_out_monitor.sv
// Op-amp output monitor: debounced saturation classifier and zero-cross detector on the moving average.
module opamp_out_monitor
   import opamp_pkg::*;
#(
   parameter int WIDTH      = SAMPLE_W,
   parameter int AVG_LOG2   = 3,
   parameter int SAMPLE_DIV = 4,
   parameter int SAT_HI     = SAT_HI_DEF,
   parameter int SAT_LO     = SAT_LO_DEF,
   parameter int HYST       = HYST_DEF,
   parameter int DEBOUNCE   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   opamp_out_monitor_if.slave bus
);
   localparam logic signed [WIDTH-1:0] HI_T    = WIDTH'(SAT_HI);
   localparam logic signed [WIDTH-1:0] LO_T    = WIDTH'(SAT_LO);
   localparam logic signed [WIDTH-1:0] HI_EXIT = WIDTH'(SAT_HI - HYST);
   localparam logic signed [WIDTH-1:0] LO_EXIT = WIDTH'(SAT_LO + HYST);

   logic signed [WIDTH-1:0] avg;
   logic                    avg_vld;
   state_e                  state_q, state_d, tgt, dbc_tgt_q, dbc_tgt_d;
   logic                    has_tgt;
   logic [7:0]              dbc_q, dbc_d, dbc_n;
   logic                    sat_pos_q, sat_neg_q, zc_q, prev_neg_q, have_prev_q;

   opamp_mavg #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2), .SAMPLE_DIV(SAMPLE_DIV)) u_mavg (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (bus.en),
      .vin_i       (bus.vin),
      .avg_o       (avg),
      .avg_valid_o (avg_vld)
   );

   always_comb begin
      has_tgt = 1'b0;
      tgt     = state_q;
      case (state_q)
         ST_LINEAR: begin
            if (avg >= HI_T)      begin has_tgt = 1'b1; tgt = ST_SAT_POS; end
            else if (avg <= LO_T) begin has_tgt = 1'b1; tgt = ST_SAT_NEG; end
         end
         ST_SAT_POS: begin
            if (avg <= LO_T)                          begin has_tgt = 1'b1; tgt = ST_SAT_NEG; end
            else if (avg < HI_EXIT && avg > LO_T)     begin has_tgt = 1'b1; tgt = ST_LINEAR;  end
         end
         ST_SAT_NEG: begin
            if (avg >= HI_T)                          begin has_tgt = 1'b1; tgt = ST_SAT_POS; end
            else if (avg > LO_EXIT && avg < HI_T)     begin has_tgt = 1'b1; tgt = ST_LINEAR;  end
         end
         default: ;
      endcase

      // A different candidate than last time restarts the run at one.
      dbc_n     = (dbc_q != 8'd0 && tgt == dbc_tgt_q) ? dbc_q + 8'd1 : 8'd1;
      state_d   = state_q;
      dbc_d     = dbc_q;
      dbc_tgt_d = dbc_tgt_q;
      if (avg_vld) begin
         if (state_q == ST_INIT) begin
            state_d = ST_LINEAR;
            dbc_d   = 8'd0;
         end else if (!has_tgt) begin
            dbc_d = 8'd0;
         end else if (dbc_n >= 8'(DEBOUNCE)) begin
            state_d = tgt;
            dbc_d   = 8'd0;
         end else begin
            dbc_d     = dbc_n;
            dbc_tgt_d = tgt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         dbc_q       <= 8'd0;
         dbc_tgt_q   <= ST_INIT;
         sat_pos_q   <= 1'b0;
         sat_neg_q   <= 1'b0;
         zc_q        <= 1'b0;
         prev_neg_q  <= 1'b0;
         have_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dbc_q     <= dbc_d;
         dbc_tgt_q <= dbc_tgt_d;
         sat_pos_q <= (state_d == ST_SAT_POS);
         sat_neg_q <= (state_d == ST_SAT_NEG);
         zc_q      <= avg_vld && have_prev_q && (avg[WIDTH-1] != prev_neg_q);
         if (avg_vld) begin
            prev_neg_q  <= avg[WIDTH-1];
            have_prev_q <= 1'b1;
         end
      end
   end

   assign bus.avg_out    = avg;
   assign bus.avg_valid  = avg_vld;
   assign bus.state      = state_q;
   assign bus.sat_pos    = sat_pos_q;
   assign bus.sat_neg    = sat_neg_q;
   assign bus.zero_cross = zc_q;
endmodule

// File: tb/tb_opamp_out_monitor.sv
// Directed scenarios plus random stimulus, checked every cycle against a behavioural model.
module tb_opamp_out_monitor;
   import opamp_pkg::*;

   localparam int DIV = 4;
   localparam int DEB = 4;
   localparam int N   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   opamp_out_monitor_if bus ();
   opamp_out_monitor #(.SAMPLE_DIV(DIV), .DEBOUNCE(DEB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // behavioural model state
   int m_div, m_avg, m_state, m_prev;
   int m_win[$];
   int m_hist[$];
   bit m_pend, m_valid, m_zc, m_have, m_strobed;

   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int floor_div(int s);
      return (s >= 0) ? s / N : -((-s + N - 1) / N);
   endfunction

   // Which state a given average argues for, or -1 if none.
   function automatic int target(int st, int a);
      case (st)
         1: return (a >= 12000) ? 2 : (a <= -12000) ? 3 : -1;
         2: return (a <= -12000) ? 3 : (a < 11500 && a > -12000) ? 1 : -1;
         3: return (a >= 12000) ? 2 : (a > -11500 && a < 12000) ? 1 : -1;
         default: return -1;
      endcase
   endfunction

   always @(posedge clk) begin : model
      int t, s;
      bit all;
      m_strobed = 1'b0;
      if (!rst_n) begin
         m_div = 0; m_avg = 0; m_state = 0; m_prev = 0;
         m_win.delete(); m_hist.delete();
         m_pend = 0; m_valid = 0; m_zc = 0; m_have = 0;
      end else begin
         m_zc = 1'b0;
         if (m_valid) begin
            if (m_state == 0) begin
               m_state = 1;
               m_hist.delete();
            end else begin
               t = target(m_state, m_avg);
               m_hist.push_back(t);
               if (m_hist.size() > DEB) void'(m_hist.pop_front());
               if (t >= 0 && m_hist.size() == DEB) begin
                  all = 1'b1;
                  foreach (m_hist[i]) if (m_hist[i] != t) all = 1'b0;
                  if (all) begin
                     m_state = t;
                     m_hist.delete();
                  end
               end
            end
            if (m_have && ((m_avg < 0) != (m_prev < 0))) m_zc = 1'b1;
            m_prev = m_avg;
            m_have = 1'b1;
         end
         m_valid = 1'b0;
         if (m_pend && m_win.size() == N) begin
            s = 0;
            foreach (m_win[i]) s += m_win[i];
            m_avg   = floor_div(s);
            m_valid = 1'b1;
         end
         m_pend = 1'b0;
         if (bus.en) begin
            if (m_div == DIV - 1) begin
               m_div = 0;
               m_win.push_back(int'(bus.vin));
               if (m_win.size() > N) void'(m_win.pop_front());
               m_pend    = 1'b1;
               m_strobed = 1'b1;
            end else begin
               m_div++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("avg_out",    int'(bus.avg_out),   m_avg);
         chk("avg_valid",  int'(bus.avg_valid), int'(m_valid));
         chk("state",      int'(bus.state),     m_state);
         chk("sat_pos",    int'(bus.sat_pos),   int'(m_state == 2));
         chk("sat_neg",    int'(bus.sat_neg),   int'(m_state == 3));
         chk("zero_cross", int'(bus.zero_cross), int'(m_zc));
      end
   end

   task automatic wait_valid(string nm);
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.avg_valid && n < 4 * DIV);
      if (!bus.avg_valid) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic feed(int v);
      int n = 0;
      bus.vin = 16'(v);
      do begin @(posedge clk); #1; n++; end while (!m_strobed && n < 2 * DIV);
      if (!m_strobed) chk("feed_timeout", 0, 1);
      @(negedge clk);
   endtask

   function automatic logic signed [15:0] pick(int mode);
      int v;
      case (mode)
         0: v = 12000 + int'($urandom_range(0, 3000));
         1: v = -12000 - int'($urandom_range(0, 3000));
         2: v = int'($urandom_range(0, 4000)) - 2000;
         default: v = int'($urandom_range(0, 65535)) - 32768;
      endcase
      return 16'(v);
   endfunction

   initial begin
      int n, cnt, zc, mode;
      bit got;
      bus.en = 1'b0; bus.vin = '0; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      chk("rst_state", int'(bus.state), 0);
      chk("rst_avg",   int'(bus.avg_out), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // fill with a constant and enter LINEAR
      bus.en = 1'b1; bus.vin = 16'sd1000;
      n = 0; got = 1'b0;
      while (n < 100 && !got) begin @(posedge clk); n++; #1; got = bus.avg_valid; end
      chk("fill_latency", n, 33);
      chk("fill_avg", int'(bus.avg_out), 1000);
      @(posedge clk); #1;
      chk("linear_state", int'(bus.state), 1);
      @(negedge clk);

      // ramp into positive saturation
      bus.vin = 16'sd13000;
      for (int k = 0; k < 8; k++) begin
         wait_valid("ramp");
         chk("ramp_avg", int'(bus.avg_out), 2500 + 1500 * k);
      end
      cnt = 8; n = 0;
      while (!bus.sat_pos && n < 60) begin @(posedge clk); #1; n++; if (bus.avg_valid) cnt++; end
      chk("sat_pos_avgs", cnt, 11);
      chk("sat_pos_state", int'(bus.state), 2);
      @(negedge clk);

      // swing to negative saturation
      bus.vin = -16'sd13000;
      zc = 0;
      repeat (120) begin @(negedge clk); if (bus.zero_cross) zc++; end
      chk("neg_zc_count", zc, 1);
      chk("neg_sat", int'(bus.sat_neg), 1);

      // floor rounding
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 8; k++) feed((k % 2 == 0) ? -1 : 0);
      @(negedge clk);
      chk("floor_alt_valid", int'(bus.avg_valid), 1);
      chk("floor_alt_avg", int'(bus.avg_out), -1);
      feed(6);
      for (int k = 0; k < 7; k++) feed(-1);
      @(negedge clk);
      chk("floor_six_avg", int'(bus.avg_out), -1);

      // reset while saturated
      for (int k = 0; k < 12; k++) feed(13000);
      chk("pre_reset_sat", int'(bus.sat_pos), 1);
      rst_n = 1'b0; @(negedge clk);
      chk("mid_rst_avg",   int'(bus.avg_out), 0);
      chk("mid_rst_state", int'(bus.state), 0);
      chk("mid_rst_sat",   int'(bus.sat_pos), 0);
      rst_n = 1'b1;
      n = 0; got = 1'b0;
      while (n < 100 && !got) begin @(posedge clk); n++; #1; got = bus.avg_valid; end
      chk("refill_latency", n, 33);

      // enable pause keeps the window
      @(negedge clk);
      bus.en = 1'b0; cnt = 0;
      repeat (20) begin @(negedge clk); if (bus.avg_valid) cnt++; end
      chk("pause_valids", cnt, 0);
      bus.vin = -16'sd3000; bus.en = 1'b1;
      wait_valid("resume");
      chk("resume_avg", int'(bus.avg_out), 11000);
      @(negedge clk);

      // random traffic
      mode = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 40 == 0) mode = int'($urandom_range(0, 3));
         bus.vin = pick(mode);
         bus.en  = ($urandom_range(0, 9) != 0);
         rst_n   = ($urandom_range(0, 999) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
